// File: rtl/shot_controller.sv
// Shot sequencer for the 4x4 cell game: turns a fire edge plus row/column select
// into a timed enable/strobe sequence, counts shots and decides win/loss.
module shot_controller #(
    parameter logic [7:0]  MAX_SHOTS  = 8'd12,
    parameter logic [3:0]  SETTLE_CYC = 4'd3,
    parameter logic [31:0] BOARD_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fire_lvl,
    input  logic [3:0]  sel,
    input  logic        n_row,
    input  logic        mode_add_n,
    input  logic [31:0] cell_state,
    output logic [3:0]  row_en,
    output logic [3:0]  col_en,
    output logic        fire_out,
    output logic        add_n,
    output logic        load_en,
    output logic [31:0] load_pattern,
    output logic [7:0]  shot_cnt,
    output logic        sel_error,
    output logic        won,
    output logic        lost
);

    typedef enum logic [2:0] {
        S_LOAD, S_IDLE, S_FIRE, S_SETTLE, S_CHECK, S_WON, S_LOST
    } state_t;

    state_t      state, state_d;
    logic        fire_prev;
    logic [3:0]  settle_cnt, settle_d;
    logic [3:0]  row_d, col_d;
    logic        fire_d, add_d, load_d, err_d, won_d, lost_d;
    logic [7:0]  cnt_d;
    logic        fire_rise;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    assign fire_rise    = fire_lvl & ~fire_prev;
    assign load_pattern = BOARD_INIT;

    always_comb begin
        state_d = state;
        settle_d = settle_cnt;
        row_d   = row_en;
        col_d   = col_en;
        fire_d  = 1'b0;
        add_d   = add_n;
        load_d  = 1'b0;
        cnt_d   = shot_cnt;
        err_d   = sel_error;
        won_d   = won;
        lost_d  = lost;
        case (state)
            S_LOAD: begin
                load_d  = 1'b1;
                cnt_d   = 8'd0;
                won_d   = 1'b0;
                lost_d  = 1'b0;
                err_d   = 1'b0;
                row_d   = 4'd0;
                col_d   = 4'd0;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (fire_rise) begin
                    if (is_one_hot(sel)) begin
                        row_d   = n_row ? 4'd0 : sel;
                        col_d   = n_row ? sel : 4'd0;
                        add_d   = mode_add_n;
                        err_d   = 1'b0;
                        state_d = S_FIRE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FIRE: begin
                fire_d   = 1'b1;
                settle_d = 4'd0;
                state_d  = S_SETTLE;
            end
            // Enables stay up for the strobe cycle plus SETTLE_CYC more.
            S_SETTLE: begin
                if (settle_cnt == SETTLE_CYC) begin
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    cnt_d   = sat_inc(shot_cnt);
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_cnt + 4'd1;
                end
            end
            S_CHECK: begin
                if (cell_state == 32'd0) begin
                    won_d   = 1'b1;
                    state_d = S_WON;
                end else if (shot_cnt == MAX_SHOTS) begin
                    lost_d  = 1'b1;
                    state_d = S_LOST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WON, S_LOST: begin
                if (fire_rise) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_LOAD;
            fire_prev  <= 1'b0;
            settle_cnt <= 4'd0;
            row_en     <= 4'd0;
            col_en     <= 4'd0;
            fire_out   <= 1'b0;
            add_n      <= 1'b0;
            load_en    <= 1'b0;
            shot_cnt   <= 8'd0;
            sel_error  <= 1'b0;
            won        <= 1'b0;
            lost       <= 1'b0;
        end else begin
            state      <= state_d;
            fire_prev  <= fire_lvl;
            settle_cnt <= settle_d;
            row_en     <= row_d;
            col_en     <= col_d;
            fire_out   <= fire_d;
            add_n      <= add_d;
            load_en    <= load_d;
            shot_cnt   <= cnt_d;
            sel_error  <= err_d;
            won        <= won_d;
            lost       <= lost_d;
        end
    end

endmodule
